debug_unlock_controller: RTL

- Host-side access controller for the target's debug port; it drives the target's debug_enable and consumes its debug_data.
- A debug host talks to it over a byte-wide valid/ready command/response channel.
- Debug visibility is granted only after a 32-bit unlock key is presented. Consecutive failures cause a timed lockout, and an idle session relocks automatically.
- Placed between the external debug transport and the debug-capable target block.

---
 rtl/debug_unlock_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/debug_unlock_controller.sv
// Debug port access controller: key-gated unlock, timed lockout after
// repeated failures, and automatic relock of an idle session.
module debug_unlock_controller #(
    parameter logic [31:0] KEY            = 32'hA5C3_5A3C,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 1024,
    parameter int          SESSION_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic       debug_enable,
    input  logic [7:0] debug_data,
    output logic       locked_out,
    output logic [1:0] fail_count
);

    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int SW = $clog2(SESSION_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [SW-1:0] SESS_LAST = SW'(SESSION_CYCLES - 1);
    localparam logic [1:0]    FAIL_MAX  = 2'(MAX_FAIL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_CHECK,
        S_RESP,
        S_LOCKOUT
    } state_t;

    state_t        state, state_nx;
    logic          unlocked, unlocked_nx;
    logic [31:0]   key_sr, key_sr_nx;
    logic [1:0]    byte_cnt, byte_cnt_nx;
    logic [LW-1:0] lock_cnt, lock_cnt_nx;
    logic [SW-1:0] sess_cnt, sess_cnt_nx;
    logic [1:0]    fail_nx, fail_inc;
    logic          rsp_valid_nx;
    logic [7:0]    rsp_data_nx;
    logic          accept, consume;

    assign accept  = cmd_valid & cmd_ready;
    assign consume = rsp_valid & rsp_ready;
    assign fail_inc = (fail_count == FAIL_MAX) ? fail_count
                                               : fail_count + 2'd1;

    // Next-state, key capture, response selection and session timer.
    always_comb begin
        state_nx     = state;
        unlocked_nx  = unlocked;
        key_sr_nx    = key_sr;
        byte_cnt_nx  = byte_cnt;
        lock_cnt_nx  = lock_cnt;
        sess_cnt_nx  = sess_cnt;
        fail_nx      = fail_count;
        rsp_valid_nx = rsp_valid;
        rsp_data_nx  = rsp_data;

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        (cmd_data == 8'h55): begin
                            unlocked_nx = 1'b0;
                            byte_cnt_nx = 2'd0;
                            state_nx    = S_KEY;
                        end
                        (cmd_data == 8'hAA): begin
                            rsp_data_nx  = unlocked ? debug_data : 8'h00;
                            rsp_valid_nx = 1'b1;
                            state_nx     = S_RESP;
                        end
                        (cmd_data == 8'h0F): begin
                            unlocked_nx  = 1'b0;
                            rsp_data_nx  = 8'h02;
                            rsp_valid_nx = 1'b1;
                            state_nx     = S_RESP;
                        end
                        default: begin
                            rsp_data_nx  = 8'hFF;
                            rsp_valid_nx = 1'b1;
                            state_nx     = S_RESP;
                        end
                    endcase
                end
            end
            S_KEY: begin
                if (accept) begin
                    key_sr_nx   = {key_sr[23:0], cmd_data};
                    byte_cnt_nx = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                key_sr_nx    = 32'd0;
                rsp_valid_nx = 1'b1;
                if (key_sr == KEY) begin
                    unlocked_nx = 1'b1;
                    fail_nx     = 2'd0;
                    rsp_data_nx = 8'h01;
                    state_nx    = S_RESP;
                end else begin
                    fail_nx     = fail_inc;
                    rsp_data_nx = 8'hEE;
                    if (fail_inc == FAIL_MAX) begin
                        lock_cnt_nx = '0;
                        state_nx    = S_LOCKOUT;
                    end else begin
                        state_nx = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (consume) begin
                    rsp_valid_nx = 1'b0;
                    state_nx     = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (consume) rsp_valid_nx = 1'b0;
                if (lock_cnt == LOCK_LAST) begin
                    if (!rsp_valid || consume) begin
                        fail_nx  = 2'd0;
                        state_nx = S_IDLE;
                    end
                end else begin
                    lock_cnt_nx = lock_cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (accept || !unlocked) begin
            sess_cnt_nx = '0;
        end else if (state == S_IDLE) begin
            if (sess_cnt == SESS_LAST) begin
                sess_cnt_nx = '0;
                unlocked_nx = 1'b0;
            end else begin
                sess_cnt_nx = sess_cnt + 1'b1;
            end
        end
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            unlocked     <= 1'b0;
            key_sr       <= 32'd0;
            byte_cnt     <= 2'd0;
            lock_cnt     <= '0;
            sess_cnt     <= '0;
            fail_count   <= 2'd0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 8'h00;
            cmd_ready    <= 1'b0;
            locked_out   <= 1'b0;
            debug_enable <= 1'b0;
        end else begin
            state        <= state_nx;
            unlocked     <= unlocked_nx;
            key_sr       <= key_sr_nx;
            byte_cnt     <= byte_cnt_nx;
            lock_cnt     <= lock_cnt_nx;
            sess_cnt     <= sess_cnt_nx;
            fail_count   <= fail_nx;
            rsp_valid    <= rsp_valid_nx;
            rsp_data     <= rsp_data_nx;
            cmd_ready    <= (state_nx == S_IDLE) || (state_nx == S_KEY);
            locked_out   <= (state_nx == S_LOCKOUT);
            debug_enable <= unlocked;
        end
    end

endmodule
